// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - raster-order frame memory reader driving a valid/ready pixel stream
// Optional per-beat m_border output is enabled by PIXEL_STREAM_TX_BORDER_EN.
module pixel_stream_tx #(
  parameter int DATA_W     = 8,
  parameter int MAX_WIDTH  = 512,
  parameter int MAX_HEIGHT = 512,
  parameter int ADDR_W     = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       img_height,
  input  logic [15:0]       img_width,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
`ifdef PIXEL_STREAM_TX_BORDER_EN
  ,
  output logic              m_border
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_STREAM, S_DRAIN, S_FINISH} state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);
  localparam logic [15:0] MAX_H = 16'(MAX_HEIGHT);

  state_t state, state_nxt;

  logic [15:0]       width_q, height_q, row_q, col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              rd_pend_q;
  logic [2:0]        rd_meta_q;
  logic [DATA_W-1:0] fifo_data [2];
  logic [2:0]        fifo_meta [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;

  logic       dims_bad, col_last, row_last, last_pix;
  logic       pop, push, issue;
  logic [2:0] occ_after;

  assign dims_bad = (width_q == 16'd0) || (height_q == 16'd0) ||
                    (width_q > MAX_W) || (height_q > MAX_H);
  assign col_last = (col_q == width_q - 16'd1);
  assign row_last = (row_q == height_q - 16'd1);
  assign last_pix = col_last && row_last;

  // Occupancy the buffer will reach counting the read already in flight; a new
  // read may only be issued when a slot is guaranteed for its data.
  assign m_valid   = (count != 2'd0);
  assign pop       = m_valid && m_ready;
  assign push      = rd_pend_q;
  assign occ_after = {1'b0, count} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = (state == S_STREAM) && (occ_after < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = dims_bad ? S_FINISH : S_STREAM;
      S_STREAM: if (issue && last_pix) state_nxt = S_DRAIN;
      S_DRAIN:  if (pop && fifo_meta[rd_ptr][0]) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

`ifdef PIXEL_STREAM_TX_BORDER_EN
  logic rd_border_q;
  logic fifo_border [2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q   <= '0;
      height_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_meta_q <= '0;
`ifdef PIXEL_STREAM_TX_BORDER_EN
      rd_border_q <= 1'b0;
`endif
    end else begin
      rd_pend_q <= issue;
      if (state == S_IDLE && start) begin
        width_q  <= img_width;
        height_q <= img_height;
        err_q    <= 1'b0;
      end
      if (state == S_CHECK) begin
        if (dims_bad) begin
          err_q <= 1'b1;
        end else begin
          addr_q <= '0;
          row_q  <= '0;
          col_q  <= '0;
        end
      end
      if (issue) begin
        rd_meta_q <= {(row_q == 16'd0) && (col_q == 16'd0), col_last, last_pix};
`ifdef PIXEL_STREAM_TX_BORDER_EN
        rd_border_q <= (row_q == 16'd0) || row_last || (col_q == 16'd0) || col_last;
`endif
        if (!last_pix) addr_q <= addr_q + ADDR_W'(1);
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

  // Two-entry output buffer; each entry carries its pixel and markers together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_meta[i] <= '0;
`ifdef PIXEL_STREAM_TX_BORDER_EN
        fifo_border[i] <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_meta[wr_ptr] <= rd_meta_q;
`ifdef PIXEL_STREAM_TX_BORDER_EN
        fifo_border[wr_ptr] <= rd_border_q;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_data = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_sof  = m_valid && fifo_meta[rd_ptr][2];
  assign m_eol  = m_valid && fifo_meta[rd_ptr][1];
  assign m_eof  = m_valid && fifo_meta[rd_ptr][0];
`ifdef PIXEL_STREAM_TX_BORDER_EN
  assign m_border = m_valid && fifo_border[rd_ptr];
`endif

  assign busy        = (state == S_CHECK) || (state == S_STREAM) || (state == S_DRAIN);
  assign done        = (state == S_FINISH);
  assign err         = err_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - directed self-checking bench for pixel_stream_tx
// Border checks are compiled in when PIXEL_STREAM_TX_BORDER_EN is defined.
module tb_pixel_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] img_height = '0;
  logic [15:0] img_width = '0;
  logic        busy, done, err, mem_rd_en;
  logic [17:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_sof, m_eol, m_eof;
`ifdef PIXEL_STREAM_TX_BORDER_EN
  logic        m_border;
`endif

  pixel_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_height(img_height), .img_width(img_width),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
`ifdef PIXEL_STREAM_TX_BORDER_EN
    , .m_border(m_border)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];

  int n_cmp = 0;
  int n_bad = 0;

  int n_beats, n_reads, n_valid, n_done, n_unstable, max_out, data_bad;
  int first_rd_c, first_valid_c, last_beat_c, done_c;
  logic [17:0] first_rd_addr;
  logic        busy_at_done, last_busy;
  logic [63:0] sof_mask, eol_mask, eof_mask, border_mask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] base);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + base);
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
    start = 1'b1;
    img_width = w;
    img_height = h;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs a fixed number of cycles starting in the CHECK cycle, applying the
  // ready pattern on cycles where m_valid is high, and gathering statistics.
  task automatic collect(input int cycles, input logic [15:0] pat, input int pat_len,
                         input int inj_c, input logic [7:0] base);
    int p = 0;
    logic stall = 1'b0;
    logic [7:0] pd = '0;
    logic [2:0] pm = '0;
    n_beats = 0; n_reads = 0; n_valid = 0; n_done = 0; n_unstable = 0;
    max_out = 0; data_bad = 0;
    first_rd_c = -1; first_valid_c = -1; last_beat_c = -1; done_c = -1;
    first_rd_addr = '1; busy_at_done = 1'bx; last_busy = 1'bx;
    sof_mask = '0; eol_mask = '0; eof_mask = '0; border_mask = '0;
    for (int c = 0; c < cycles; c++) begin
      m_ready = (m_valid && p < pat_len) ? pat[p] : 1'b1;
      if (m_valid) p++;
      if (c == inj_c) begin
        start = 1'b1; img_width = 16'd2; img_height = 16'd2;
      end
      #1;
      if (mem_rd_en) begin
        if (n_reads == 0) begin first_rd_c = c; first_rd_addr = mem_rd_addr; end
        n_reads++;
      end
      if (stall && (!m_valid || m_data !== pd || {m_sof, m_eol, m_eof} !== pm)) n_unstable++;
      if (m_valid) begin
        if (n_valid == 0) first_valid_c = c;
        n_valid++;
      end
      if (m_valid && m_ready) begin
        if (m_data !== 8'(base + n_beats)) data_bad++;
        if (n_beats < 64) begin
          sof_mask[n_beats] = m_sof;
          eol_mask[n_beats] = m_eol;
          eof_mask[n_beats] = m_eof;
`ifdef PIXEL_STREAM_TX_BORDER_EN
          border_mask[n_beats] = m_border;
`endif
        end
        last_beat_c = c;
        last_busy = busy;
        n_beats++;
      end
      if (n_reads - n_beats > max_out) max_out = n_reads - n_beats;
      if (done) begin n_done++; done_c = c; busy_at_done = busy; end
      stall = m_valid && !m_ready;
      pd = m_data;
      pm = {m_sof, m_eol, m_eof};
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    int nb;
    int nd;
    fill_mem(8'd10);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_markers", 64'({m_sof, m_eol, m_eof}), 64'd0);
    check("rst_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean 3 rows x 4 columns frame, data 10..21
    start_frame(16'd4, 16'd3);
    check("clean_busy_check", 64'(busy), 64'd1);
    collect(20, 16'h0, 0, -1, 8'd10);
    check("clean_beats", 64'(n_beats), 64'd12);
    check("clean_data", 64'(data_bad), 64'd0);
    check("clean_reads", 64'(n_reads), 64'd12);
    check("clean_first_rd_c", 64'(first_rd_c), 64'd1);
    check("clean_first_rd_addr", 64'(first_rd_addr), 64'd0);
    check("clean_first_valid_c", 64'(first_valid_c), 64'd3);
    check("clean_valid_cycles", 64'(n_valid), 64'd12);
    check("clean_last_beat_c", 64'(last_beat_c), 64'd14);
    check("clean_sof", sof_mask, 64'h1);
    check("clean_eol", eol_mask, 64'h888);
    check("clean_eof", eof_mask, 64'h800);
    check("clean_done_count", 64'(n_done), 64'd1);
    check("clean_done_c", 64'(done_c), 64'd15);
    check("clean_busy_at_done", 64'(busy_at_done), 64'd0);
    check("clean_busy_last_beat", 64'(last_busy), 64'd1);

    // Back-pressure 2x2, ready pattern 1,0,0,1,0,1,1
    fill_mem(8'd0);
    start_frame(16'd2, 16'd2);
    collect(30, 16'h0069, 7, -1, 8'd0);
    check("bp_beats", 64'(n_beats), 64'd4);
    check("bp_data", 64'(data_bad), 64'd0);
    check("bp_valid_cycles", 64'(n_valid), 64'd7);
    check("bp_unstable", 64'(n_unstable), 64'd0);
    check("bp_max_outstanding", 64'(max_out <= 2), 64'd1);
    check("bp_eol", eol_mask, 64'hA);
    check("bp_eof", eof_mask, 64'h8);
    check("bp_done_count", 64'(n_done), 64'd1);

    // 1x1 frame
    fill_mem(8'd10);
    start_frame(16'd1, 16'd1);
    collect(12, 16'h0, 0, -1, 8'd10);
    check("one_beats", 64'(n_beats), 64'd1);
    check("one_data", 64'(data_bad), 64'd0);
    check("one_markers", 64'({sof_mask[0], eol_mask[0], eof_mask[0]}), 64'd7);
    check("one_done_count", 64'(n_done), 64'd1);

    // width 1, height 3
    start_frame(16'd1, 16'd3);
    collect(14, 16'h0, 0, -1, 8'd10);
    check("col_beats", 64'(n_beats), 64'd3);
    check("col_data", 64'(data_bad), 64'd0);
    check("col_eol", eol_mask, 64'h7);
    check("col_sof", sof_mask, 64'h1);
    check("col_eof", eof_mask, 64'h4);

    // Bad dimensions then recovery
    start_frame(16'd0, 16'd2);
    collect(6, 16'h0, 0, -1, 8'd10);
    check("bad_reads", 64'(n_reads), 64'd0);
    check("bad_valid", 64'(n_valid), 64'd0);
    check("bad_done_count", 64'(n_done), 64'd1);
    check("bad_done_c", 64'(done_c), 64'd1);
    check("bad_err", 64'(err), 64'd1);
    start_frame(16'd2, 16'd2);
    check("rec_err_cleared", 64'(err), 64'd0);
    collect(20, 16'h0, 0, -1, 8'd10);
    check("rec_beats", 64'(n_beats), 64'd4);
    check("rec_data", 64'(data_bad), 64'd0);
    check("rec_done_count", 64'(n_done), 64'd1);

    // Reset after beat 5 of an 8x8 frame
    start_frame(16'd8, 16'd8);
    m_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 40 && nb < 5; c++) begin
      #1;
      if (m_valid && m_ready) nb++;
      @(posedge clk); #1;
    end
    check("rm_beats_before", 64'(nb), 64'd5);
    rst_n = 1'b0;
    #1;
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_valid", 64'(m_valid), 64'd0);
    check("rm_rd_en", 64'(mem_rd_en), 64'd0);
    check("rm_outs", 64'({done, err, m_sof, m_eol, m_eof}), 64'd0);
    check("rm_addr", 64'(mem_rd_addr), 64'd0);
    check("rm_data", 64'(m_data), 64'd0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("rm_no_done", 64'(nd), 64'd0);
    start_frame(16'd2, 16'd2);
    collect(20, 16'h0, 0, -1, 8'd10);
    check("rm_restart_addr", 64'(first_rd_addr), 64'd0);
    check("rm_restart_sof", sof_mask, 64'h1);
    check("rm_restart_data", 64'(data_bad), 64'd0);
    check("rm_restart_beats", 64'(n_beats), 64'd4);

    // Start pulsed mid-frame with other dimensions is ignored
    start_frame(16'd4, 16'd3);
    collect(25, 16'h0, 0, 5, 8'd10);
    check("ign_beats", 64'(n_beats), 64'd12);
    check("ign_reads", 64'(n_reads), 64'd12);
    check("ign_eof", eof_mask, 64'h800);
    check("ign_done_count", 64'(n_done), 64'd1);
    check("ign_data", 64'(data_bad), 64'd0);

`ifdef PIXEL_STREAM_TX_BORDER_EN
    start_frame(16'd3, 16'd3);
    collect(20, 16'h0, 0, -1, 8'd10);
    check("brd_beats", 64'(n_beats), 64'd9);
    check("brd_mask", border_mask, 64'h1EF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
